// File: rtl/turbo_frame_sched_pkg.sv
// rtl/turbo_frame_sched_pkg.sv - shared state encoding and default sizes for the turbo frame sequencer
package turbo_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        TAIL  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5,
        ABORT = 3'd6
    } state_e;

    localparam int unsigned FRAME_LEN_DEF = 40;
    localparam int unsigned TAIL_LEN_DEF  = 3;
    localparam int unsigned DRAIN_LEN_DEF = 4;
    localparam int unsigned DIV_DEF       = 2;
    localparam int unsigned CNT_W_DEF     = 8;

endpackage

// File: rtl/turbo_frame_sched_if.sv
// rtl/turbo_frame_sched_if.sv - source bit stream handshake between bit source and frame sequencer
interface turbo_frame_sched_if;

    logic in_valid;
    logic in_bit;
    logic in_ready;

    modport master (output in_valid, output in_bit, input in_ready);
    modport slave  (input in_valid, input in_bit, output in_ready);

endinterface

// File: rtl/turbo_frame_sched_strobe_div.sv
// rtl/turbo_frame_sched_strobe_div.sv - free-running clock divider producing the encoder strobe tick
module strobe_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_N,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q + W'(1);
        if (sync_clr || (div_q == W'(DIV - 1))) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == W'(DIV - 1));

endmodule

// File: rtl/turbo_frame_sched.sv
// rtl/turbo_frame_sched.sv - turbo encoder frame sequencer; TURBO_SCHED_ABORT_EN adds the abort input
module turbo_frame_sched
    import turbo_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned TAIL_LEN  = TAIL_LEN_DEF,
    parameter int unsigned DRAIN_LEN = DRAIN_LEN_DEF,
    parameter int unsigned DIV       = DIV_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_N,
    input  logic                 start,
`ifdef TURBO_SCHED_ABORT_EN
    input  logic                 abort,
`endif
    turbo_frame_sched_if.slave   src,
    output logic                 enc_en,
    output logic                 enc_bit,
    output logic                 enc_clr,
    output logic                 mode,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frame_cnt
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               enc_en_q, enc_en_d;
    logic               enc_bit_q, enc_bit_d;
    logic               enc_clr_q, enc_clr_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               tick;
    logic               take;
    logic               abort_req;

    // Divider restarts in CLEAR so the first data tick lands DIV cycles into LOAD.
    strobe_div #(.DIV(DIV)) u_div (
        .clk      (clk),
        .rst_N    (rst_N),
        .sync_clr (state_q == CLEAR),
        .tick     (tick)
    );

`ifdef TURBO_SCHED_ABORT_EN
    assign abort_req = abort && (state_q inside {CLEAR, LOAD, TAIL, DRAIN});
`else
    assign abort_req = 1'b0;
`endif

    assign src.in_ready = (state_q == LOAD) && tick;
    assign take         = src.in_ready && src.in_valid && !abort_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enc_en_d    = 1'b0;
        enc_bit_d   = 1'b0;
        enc_clr_d   = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        // mode trails the state by one cycle so it lines up with the registered strobe
        mode_d      = (state_q == TAIL);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    enc_clr_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                if (take) begin
                    enc_en_d  = 1'b1;
                    enc_bit_d = src.in_bit;
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = TAIL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    enc_en_d = 1'b1;
                    if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (tick) begin
                    enc_en_d = 1'b1;
                    if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                        cnt_d       = '0;
                        state_d     = DONE;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_req) begin
            state_d     = ABORT;
            cnt_d       = '0;
            enc_clr_d   = 1'b1;
            enc_en_d    = 1'b0;
            enc_bit_d   = 1'b0;
            mode_d      = 1'b0;
            done_d      = 1'b0;
            frame_cnt_d = frame_cnt_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            enc_en_q    <= 1'b0;
            enc_bit_q   <= 1'b0;
            enc_clr_q   <= 1'b0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enc_en_q    <= enc_en_d;
            enc_bit_q   <= enc_bit_d;
            enc_clr_q   <= enc_clr_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign enc_en    = enc_en_q;
    assign enc_bit   = enc_bit_q;
    assign enc_clr   = enc_clr_q;
    assign mode      = mode_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_turbo_frame_sched.sv
// tb/tb_turbo_frame_sched.sv - self-checking bench for turbo_frame_sched (DIV=2 and DIV=1 instances)
module tb_turbo_frame_sched;

    localparam int F = 8;
    localparam int T = 3;
    localparam int D = 4;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;
    localparam int P_ABORT = 4;

    logic        clk;
    logic        rst_N;
    logic        start     [2];
    logic        abort_s   [2];
    logic        in_valid  [2];
    logic        in_bit    [2];
    logic        in_ready  [2];
    logic        enc_en    [2];
    logic        enc_bit   [2];
    logic        enc_clr   [2];
    logic        mode      [2];
    logic        busy      [2];
    logic        done      [2];
    logic [15:0] frame_cnt [2];

    turbo_frame_sched_if if0 ();
    turbo_frame_sched_if if1 ();

    assign if0.in_valid = in_valid[0];
    assign if0.in_bit   = in_bit[0];
    assign in_ready[0]  = if0.in_ready;
    assign if1.in_valid = in_valid[1];
    assign if1.in_bit   = in_bit[1];
    assign in_ready[1]  = if1.in_ready;

    turbo_frame_sched #(.FRAME_LEN(F), .TAIL_LEN(T), .DRAIN_LEN(D), .DIV(2), .CNT_W(8)) u_div2 (
        .clk(clk), .rst_N(rst_N), .start(start[0]),
`ifdef TURBO_SCHED_ABORT_EN
        .abort(abort_s[0]),
`endif
        .src(if0), .enc_en(enc_en[0]), .enc_bit(enc_bit[0]), .enc_clr(enc_clr[0]),
        .mode(mode[0]), .busy(busy[0]), .done(done[0]), .frame_cnt(frame_cnt[0])
    );

    turbo_frame_sched #(.FRAME_LEN(F), .TAIL_LEN(T), .DRAIN_LEN(D), .DIV(1), .CNT_W(8)) u_div1 (
        .clk(clk), .rst_N(rst_N), .start(start[1]),
`ifdef TURBO_SCHED_ABORT_EN
        .abort(abort_s[1]),
`endif
        .src(if1), .enc_en(enc_en[1]), .enc_bit(enc_bit[1]), .enc_clr(enc_clr[1]),
        .mode(mode[1]), .busy(busy[1]), .done(done[1]), .frame_cnt(frame_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Frame model: strobes fall on a fixed tick grid anchored at the start cycle;
    // a frame is F data strobes, then T tail strobes, then D drain strobes.
    int cyc = 0;
    int divs     [2] = '{2, 1};
    int m_p      [2] = '{P_IDLE, P_IDLE};
    int m_s      [2] = '{0, 0};
    int m_n      [2] = '{0, 0};
    int m_frames [2] = '{0, 0};
    bit e_en [2], e_bit [2], e_clr [2], e_mode [2], e_busy [2], e_done [2];

    function automatic bit grid(input int i, input int c);
        return ((c - m_s[i] - 2) % divs[i]) == divs[i] - 1;
    endfunction

    task automatic model_reset(input int i);
        m_p[i] = P_IDLE; m_n[i] = 0; m_frames[i] = 0;
        e_en[i] = 0; e_bit[i] = 0; e_clr[i] = 0; e_mode[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    endtask

    task automatic model_step(input int i);
        bit tk;
        int p;
        p  = m_p[i];
        tk = (p == P_RUN) && grid(i, cyc);
        e_mode[i] = (p == P_RUN) && (m_n[i] >= F) && (m_n[i] < F + T);
        e_en[i] = 0; e_bit[i] = 0; e_clr[i] = 0; e_done[i] = 0;
        if (abort_s[i] && (p == P_CLEAR || p == P_RUN)) begin
            m_p[i] = P_ABORT; e_clr[i] = 1; e_mode[i] = 0;
        end else begin
            case (p)
                P_IDLE: if (start[i]) begin m_p[i] = P_CLEAR; e_clr[i] = 1; m_s[i] = cyc; end
                P_CLEAR: begin m_p[i] = P_RUN; m_n[i] = 0; end
                P_RUN: if (tk && (m_n[i] >= F || in_valid[i])) begin
                    e_en[i]  = 1;
                    e_bit[i] = (m_n[i] < F) ? in_bit[i] : 1'b0;
                    m_n[i]++;
                    if (m_n[i] == F + T + D) begin
                        m_p[i] = P_DONE; e_done[i] = 1; m_frames[i] = (m_frames[i] + 1) % 65536;
                    end
                end
                default: m_p[i] = P_IDLE;
            endcase
        end
        e_busy[i] = (m_p[i] != P_IDLE);
    endtask

    initial begin
        model_reset(0); model_reset(1);
        forever begin
            @(posedge clk or negedge rst_N);
            if (!rst_N) begin
                model_reset(0); model_reset(1);
            end else begin
                model_step(0); model_step(1);
                cyc++;
            end
        end
    end

    // Source: presents the pattern bit indexed by the number of accepted handshakes.
    logic [7:0] pat = 8'b10110010;
    int  idx [2] = '{0, 0};
    bit  hs  [2] = '{0, 0};
    initial begin
        in_bit[0] = 0; in_bit[1] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (start[i]) idx[i] = 0;
                else if (hs[i]) idx[i]++;
            end
            #1;
            for (int i = 0; i < 2; i++) in_bit[i] = pat[7 - (idx[i] % 8)];
        end
    end

    bit cap_bits [$];
    bit cap_mode [$];
    int done_cnt [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};
    int clr_cyc  [2] = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bit e_rdy;
                e_rdy = (m_p[i] == P_RUN) && (m_n[i] < F) && grid(i, cyc);
                chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(e_rdy));
                chk($sformatf("enc_en[%0d]", i),   32'(enc_en[i]),   32'(e_en[i]));
                chk($sformatf("enc_bit[%0d]", i),  32'(enc_bit[i]),  32'(e_bit[i]));
                chk($sformatf("enc_clr[%0d]", i),  32'(enc_clr[i]),  32'(e_clr[i]));
                chk($sformatf("mode[%0d]", i),     32'(mode[i]),     32'(e_mode[i]));
                chk($sformatf("busy[%0d]", i),     32'(busy[i]),     32'(e_busy[i]));
                chk($sformatf("done[%0d]", i),     32'(done[i]),     32'(e_done[i]));
                chk($sformatf("frame_cnt[%0d]", i), 32'(frame_cnt[i]), 32'(m_frames[i]));
                hs[i] = in_ready[i] && in_valid[i];
                if (done[i] === 1'b1) begin done_cnt[i]++; done_cyc[i] = cyc; end
                if (enc_clr[i] === 1'b1) clr_cyc[i] = cyc;
            end
            if (enc_clr[0] === 1'b1) begin cap_bits.delete(); cap_mode.delete(); end
            if (enc_en[0] === 1'b1) begin cap_bits.push_back(enc_bit[0]); cap_mode.push_back(mode[0]); end
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input int i, output int t0);
        start[i] = 1'b1;
        t0 = cyc;
        tick_wait(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int t0, input int exp_len, input string tag);
        int d0;
        int k;
        d0 = done_cnt[i];
        k  = 0;
        while (done_cnt[i] == d0 && k < 200) begin tick_wait(1); k++; end
        if (done_cnt[i] == d0) chk({tag, "_done_timeout"}, 0, 1);
        else chk({tag, "_done_latency"}, done_cyc[i] - t0, exp_len);
    endtask

    task automatic check_capture(input string tag);
        logic [7:0] got;
        int lead0, m1;
        got = '0;
        lead0 = 0;
        m1 = 0;
        for (int k = 0; k < 8 && k < cap_bits.size(); k++) got[7 - k] = cap_bits[k];
        while (lead0 < cap_mode.size() && cap_mode[lead0] == 1'b0) lead0++;
        foreach (cap_mode[k]) if (cap_mode[k]) m1++;
        chk({tag, "_data_bits"}, 32'(got), 32'(8'b10110010));
        chk({tag, "_data_strobes"}, lead0, 8);
        chk({tag, "_tail_strobes"}, m1, 3);
        chk({tag, "_drain_strobes"}, cap_bits.size() - lead0 - m1, 4);
    endtask

    initial begin
        int t0;
        int d0;
        rst_N = 1'b0;
        for (int i = 0; i < 2; i++) begin start[i] = 0; abort_s[i] = 0; in_valid[i] = 0; end
        tick_wait(3);
        chk("reset_frame_cnt", 32'(frame_cnt[0]), 0);
        chk("reset_busy", 32'(busy[0]), 0);
        rst_N = 1'b1;
        tick_wait(2);

        // continuous valid
        in_valid[0] = 1'b1;
        begin_frame(0, t0);
        wait_done(0, t0, 32, "t1");
        chk("t1_frame_cnt", 32'(frame_cnt[0]), 1);
        check_capture("t1");

        // source stalls for three ticks after the fourth bit
        begin_frame(0, t0);
        tick_wait(9);
        in_valid[0] = 1'b0;
        tick_wait(6);
        in_valid[0] = 1'b1;
        wait_done(0, t0, 38, "t2");
        chk("t2_frame_cnt", 32'(frame_cnt[0]), 2);
        check_capture("t2");

        // start during TAIL must be ignored
        begin_frame(0, t0);
        d0 = done_cnt[0];
        tick_wait(19);
        chk("t3_mode_in_tail", 32'(mode[0]), 1);
        start[0] = 1'b1;
        tick_wait(1);
        start[0] = 1'b0;
        wait_done(0, t0, 32, "t3");
        tick_wait(10);
        chk("t3_single_done", done_cnt[0] - d0, 1);
        chk("t3_busy_idle", 32'(busy[0]), 0);
        chk("t3_frame_cnt", 32'(frame_cnt[0]), 3);

        // asynchronous reset after five bits
        begin_frame(0, t0);
        tick_wait(11);
        chk("t4_enc_en_before_rst", 32'(enc_en[0]), 1);
        rst_N = 1'b0;
        #1;
        chk("t4_rst_enc_en", 32'(enc_en[0]), 0);
        chk("t4_rst_busy", 32'(busy[0]), 0);
        chk("t4_rst_frame_cnt", 32'(frame_cnt[0]), 0);
        tick_wait(2);
        rst_N = 1'b1;
        tick_wait(2);
        begin_frame(0, t0);
        wait_done(0, t0, 32, "t4");
        chk("t4_clr_at_start", clr_cyc[0] - t0, 1);
        chk("t4_frame_cnt", 32'(frame_cnt[0]), 1);
        check_capture("t4");

        // DIV=1, two back-to-back frames
        in_valid[1] = 1'b1;
        begin_frame(1, t0);
        wait_done(1, t0, 17, "t5a");
        chk("t5a_clr", clr_cyc[1] - t0, 1);
        begin_frame(1, t0);
        wait_done(1, t0, 17, "t5b");
        chk("t5b_clr", clr_cyc[1] - t0, 1);
        chk("t5_frame_cnt", 32'(frame_cnt[1]), 2);

`ifdef TURBO_SCHED_ABORT_EN
        // abort during DRAIN
        begin_frame(0, t0);
        d0 = done_cnt[0];
        tick_wait(25);
        abort_s[0] = 1'b1;
        tick_wait(1);
        abort_s[0] = 1'b0;
        chk("t6_abort_clr", 32'(enc_clr[0]), 1);
        tick_wait(1);
        chk("t6_idle_after_abort", 32'(busy[0]), 0);
        tick_wait(10);
        chk("t6_no_done", done_cnt[0] - d0, 0);
        chk("t6_frame_cnt", 32'(frame_cnt[0]), 1);
`endif

        tick_wait(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
